instr_ctrl: RTL
===============

# instr_ctrl

- Instruction-sequencing controller for the 8-bit RISC CPU; it drives the ALU's opcode and operand selection.
- Holds the PC and the instruction register, and fetches 1-byte (short) or 2-byte (long) instructions from synchronous ROM.
- Decodes the 4-bit opcode, then issues the opcode, operand-source select, memory strobes and register/accumulator write enables in a fixed state sequence.
- Sits between program ROM, data RAM, register file/ACC and the ALU.

## Interface
Parameters:
- none; all widths fixed (8-bit data/address, 4-bit opcode, 4-bit reg_addr).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rom_data`  in  8  ROM read data, valid the cycle after `rom_rd`.
- `flags`  in  4  ALU flags {OF,ZF,SF,PF}.
- `rom_addr`  out  8  ROM address.
- `rom_rd`  out  1  ROM read strobe.
- `ram_addr`  out  8  RAM address (= operand byte).
- `ram_rd`  out  1  RAM read strobe, 1-cycle latency.
- `ram_wr`  out  1  RAM write strobe.
- `op`  out  4  opcode to ALU.
- `src_sel`  out  2  ALU operand source: 0 = reg file, 1 = ROM, 2 = RAM.
- `reg_addr`  out  4  register-file index, `ir[3:0]`.
- `reg_wr`  out  1  register-file write enable.
- `acc_wr`  out  1  ACC write enable.
- `pc`  out  8  program counter.
- `halted`  out  1  high in HALT state.

## Operation
Instruction format:
- byte0 = {opcode[3:0], reg_addr[3:0]}.
- Long opcodes LDO(1), LDA(2), STO(5) and JMP(14) carry byte1 = operand (address or target).

State sequence:
- FETCH: `rom_addr=pc`, `rom_rd=1` → DECODE.
- DECODE: `ir<=rom_data`; `pc<=pc+1`. Long opcode → OPF; HLT(15) → HALT; otherwise → EXEC.
- OPF: `rom_addr=pc`, `rom_rd=1` → OPL.
- OPL: `opnd<=rom_data`; `pc<=pc+1` → EXEC.
- EXEC: `op=ir[7:4]`, `src_sel` driven.
  - LDO: `rom_addr=opnd`, `rom_rd=1`.
  - LDA: `ram_rd=1`.
  - → WB.
- WB: `op` and `src_sel` held; one write strobe asserted, then → FETCH.
  - LDO/LDA/LDR → `reg_wr`.
  - PRE/ADD/SHL/SHR/SAR/INV/AND/OR/XOR → `acc_wr`.
  - STO → `ram_wr`.
  - JMP → `pc<=opnd`.
  - NOP → none.
- HALT: all strobes 0; `halted=1`; stays until `rst`.

Output rules:
- `src_sel`: LDO=1, LDA=2, else 0.
- `ram_addr=opnd` whenever the opcode is long.
- `op=NOP` outside EXEC/WB.
- Unreachable state encodings → FETCH.

## Timing
- Reset values: state FETCH, `pc=0`, `ir=0`, `opnd=0`, `op=0`, `src_sel=0`, all strobes 0, `halted=0`, `rom_addr=0`.
- Reset takes effect immediately at any point, including mid-instruction; no partial write completes after `rst` rises.
- Latency: short instruction 4 cycles (FETCH, DECODE, EXEC, WB); long instruction 6 cycles. HLT reaches HALT 2 cycles after its FETCH.
- All strobes are single-cycle pulses; at most one write strobe per instruction.
- PC wraps 0xFF→0x00. A long instruction at 0xFF takes its operand from 0x00.
- JMP target takes effect in the FETCH immediately after WB; a jump to self loops every 6 cycles.

## Configuration
- Macro `INSTR_CTRL_CONDJMP_EN`.
- Defined:
  - A 1-bit `zf_q` register (reset 0) captures `flags[2]` in WB of ADD/SHL/SHR/SAR/INV/AND/OR/XOR.
  - JMP with `ir[0]=1` loads PC only when `zf_q=1`; otherwise it falls through with pc = address after the operand.
  - JMP with `ir[0]=0` is unconditional.
- Undefined: no `zf_q`; every JMP is unconditional and `ir[3:0]` is ignored for JMP.

## Test plan
- Reset, ROM[0]=0x63 (ADD r3) → `op=6`, `src_sel=0`, `reg_addr=3` in cycles 3–4; `acc_wr` pulses in cycle 4; `pc=1`.
- ROM[0..1]=0x12,0x40 (LDO r2,0x40) → `rom_addr=0x40`, `rom_rd=1` in EXEC; `reg_wr=1`, `src_sel=1`, `reg_addr=2` in WB; 6 cycles total; `pc=2`.
- ROM[0..1]=0xE0,0x10 (JMP 0x10) → next FETCH `rom_addr=0x10`. ROM[0x10]=0xF0 → `halted=1` two cycles later and held for 20 cycles with all strobes 0.
- STO at 0xFF with operand ROM[0x00]=0x22 → `ram_addr=0x22`, `ram_wr` pulses once, `pc=0x01`.
- `rst` asserted during LDA's EXEC → `ram_rd`/`reg_wr` drop within the same cycle, `pc=0`, state FETCH; `reg_wr` never pulses.
- `INSTR_CTRL_CONDJMP_EN`: XOR producing `flags=4'b0100`, then JMP (`ir[0]=1`) to 0x30 → jump taken. With `flags=0`, the same JMP falls through.

Source files
------------

// File: rtl/instr_ctrl.sv
// Instruction-sequencing controller for the 8-bit RISC CPU: fetch, decode and strobe sequencing.
// Optional feature: define INSTR_CTRL_CONDJMP_EN for zero-flag conditional JMP (ir[0]=1).
module instr_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rom_data,
  input  logic [3:0] flags,
  output logic [7:0] rom_addr,
  output logic       rom_rd,
  output logic [7:0] ram_addr,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic [3:0] op,
  output logic [1:0] src_sel,
  output logic [3:0] reg_addr,
  output logic       reg_wr,
  output logic       acc_wr,
  output logic [7:0] pc,
  output logic       halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_OPF    = 3'd2;
  localparam logic [2:0] S_OPL    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDO = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_LDR = 4'd3;
  localparam logic [3:0] OP_PRE = 4'd4;
  localparam logic [3:0] OP_STO = 4'd5;
  localparam logic [3:0] OP_ADD = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd13;
  localparam logic [3:0] OP_JMP = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] opnd_q, opnd_d;
  logic [3:0] opc;
  logic       jmpTaken;
  logic       aluOp;

  function automatic logic isLong(input logic [3:0] code);
    return (code == OP_LDO) || (code == OP_LDA) || (code == OP_STO) || (code == OP_JMP);
  endfunction

  assign opc   = ir_q[7:4];
  assign aluOp = (opc >= OP_ADD) && (opc <= OP_XOR);

`ifdef INSTR_CTRL_CONDJMP_EN
  logic zf_q;
  logic unused_flags;
  assign unused_flags = ^{flags[3], flags[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      zf_q <= 1'b0;
    else if (state_q == S_WB && aluOp)
      zf_q <= flags[2];
  end

  assign jmpTaken = !ir_q[0] || zf_q;
`else
  logic unused_flags;
  assign unused_flags = ^flags;
  assign jmpTaken = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = rom_data;
        pc_d = pc_q + 8'd1;
        if (isLong(rom_data[7:4]))
          state_d = S_OPF;
        else if (rom_data[7:4] == OP_HLT)
          state_d = S_HALT;
        else
          state_d = S_EXEC;
      end
      S_OPF: state_d = S_OPL;
      S_OPL: begin
        opnd_d  = rom_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        state_d = S_FETCH;
        if (opc == OP_JMP && jmpTaken)
          pc_d = opnd_q;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      opnd_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
    end
  end

  // Strobes are decoded from state and masked by rst so an aborted instruction drops them at once.
  always_comb begin
    rom_addr = pc_q;
    rom_rd   = 1'b0;
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    reg_wr   = 1'b0;
    acc_wr   = 1'b0;
    op       = OP_NOP;
    src_sel  = 2'd0;
    halted   = 1'b0;
    if (state_q == S_EXEC || state_q == S_WB) begin
      op = opc;
      if (opc == OP_LDO)
        src_sel = 2'd1;
      else if (opc == OP_LDA)
        src_sel = 2'd2;
    end
    case (state_q)
      S_FETCH, S_OPF: rom_rd = 1'b1;
      S_EXEC: begin
        if (opc == OP_LDO) begin
          rom_addr = opnd_q;
          rom_rd   = 1'b1;
        end
        if (opc == OP_LDA)
          ram_rd = 1'b1;
      end
      S_WB: begin
        if (opc == OP_LDO || opc == OP_LDA || opc == OP_LDR)
          reg_wr = 1'b1;
        if (opc == OP_PRE || aluOp)
          acc_wr = 1'b1;
        if (opc == OP_STO)
          ram_wr = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    if (rst) begin
      rom_rd = 1'b0;
      ram_rd = 1'b0;
      ram_wr = 1'b0;
      reg_wr = 1'b0;
      acc_wr = 1'b0;
    end
  end

  assign ram_addr = isLong(opc) ? opnd_q : 8'h00;
  assign reg_addr = ir_q[3:0];
  assign pc       = pc_q;

endmodule
